// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared types, sizes and the rotating-priority candidate search for the
// four-requester round-robin arbiter.
package rr_decoder_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] id;
  } cand_t;

  // First requester at or after ptr (mod NUM_REQ), optionally skipping one
  // index. The scan runs from the farthest offset down to offset zero so the
  // last hit written is the highest-priority one.
  function automatic cand_t next_candidate(
    input logic [NUM_REQ-1:0] req,
    input logic [ID_W-1:0]    ptr,
    input logic               exclude_valid,
    input logic [ID_W-1:0]    exclude_id
  );
    cand_t           c;
    logic [ID_W-1:0] idx;
    c = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + i[ID_W-1:0];
      if (req[idx] && !(exclude_valid && (idx == exclude_id))) begin
        c.found = 1'b1;
        c.id    = idx;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/onehot_decode_2to4.sv
// 2-bit index to 4-bit one-hot decoder with an enable; all zero when
// disabled.
module onehot_decode_2to4 (
  input  logic [1:0] idx,
  input  logic       en,
  output logic [3:0] onehot
);

  // Shift a single set bit into position, or force zero when disabled.
  assign onehot = en ? (4'b0001 << idx) : 4'b0000;

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Four-requester round-robin arbiter. A rotating pointer picks the owner, a
// hold counter forces rotation when the owner monopolises the resource while
// someone else waits, and the grant lines are a gated decode of the
// registered owner index.
module rr_decoder_arbiter
  import rr_decoder_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_gnt_id,
  output logic               o_valid,
  output logic               o_timeout
);

  // MAX_HOLD=1 would give a zero-width counter; keep at least one bit, which
  // then simply stays at zero.
  localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic            valid;
  logic            timeout;
  logic [HC_W-1:0] hold_cnt;

  logic [ID_W-1:0]    next_ptr;
  logic [NUM_REQ-1:0] owner_mask;
  logic               others_req;
  cand_t              idle_cand;
  cand_t              rot_cand;

  // Candidate lookups: from IDLE the pointer is used as-is; on release or
  // revocation the search restarts just after the owner and skips it.
  assign next_ptr   = gnt_id + ID_W'(1);
  assign owner_mask = NUM_REQ'(1) << gnt_id;
  assign others_req = |(i_req & ~owner_mask);
  assign idle_cand  = next_candidate(i_req, ptr, 1'b0, '0);
  assign rot_cand   = next_candidate(i_req, next_ptr, 1'b1, gnt_id);

  // Arbitration FSM with registered owner, valid and timeout outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_id   <= '0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_cand.found) begin
            state    <= GRANT;
            gnt_id   <= idle_cand.id;
            valid    <= 1'b1;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (!i_req[gnt_id]) begin
            // Owner released: hand over without a bubble, or go idle.
            ptr      <= next_ptr;
            hold_cnt <= '0;
            if (rot_cand.found) begin
              gnt_id <= rot_cand.id;
            end else begin
              state <= IDLE;
              valid <= 1'b0;
            end
          end else if ((hold_cnt == HOLD_LAST) && others_req) begin
            // Owner held too long with a competitor waiting: revoke. A
            // competitor exists, so rot_cand is guaranteed to be found.
            ptr      <= next_ptr;
            gnt_id   <= rot_cand.id;
            hold_cnt <= '0;
            timeout  <= 1'b1;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HC_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

  onehot_decode_2to4 u_decode (
    .idx    (gnt_id),
    .en     (valid),
    .onehot (o_gnt)
  );

  assign o_gnt_id  = gnt_id;
  assign o_valid   = valid;
  assign o_timeout = timeout;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter (MAX_HOLD=4). A behavioural model of
// the arbitration rules is checked against the DUT after every clock edge;
// literal expectations at key points pin the model itself.
module tb_rr_decoder_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  rr_decoder_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .o_gnt     (gnt),
    .o_gnt_id  (gnt_id),
    .o_valid   (valid),
    .o_timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner = -1;   // -1 means nobody holds the resource
  int m_ptr   = 0;
  int m_held  = 0;    // edges the owner has kept the grant, unbounded
  bit m_to    = 1'b0;

  function automatic int pick(input logic [3:0] r, input int start,
                              input int excl);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (start + k) % 4;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int old;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        m_owner = pick(req, m_ptr, -1);
        m_held  = 0;
      end else if (!req[m_owner]) begin
        old     = m_owner;
        m_ptr   = (old + 1) % 4;
        m_owner = pick(req, m_ptr, old);
        m_held  = 0;
      end else if (m_held >= MAX_HOLD - 1 && (req & ~(4'b1 << m_owner)) != 4'b0) begin
        old     = m_owner;
        m_ptr   = (old + 1) % 4;
        m_owner = pick(req, m_ptr, old);
        m_held  = 0;
        m_to    = 1'b1;
      end else begin
        m_held++;
      end
    end
    #1;
    check("model_valid",   32'(valid),   32'(m_owner >= 0));
    check("model_gnt",     32'(gnt),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("model_timeout", 32'(timeout), 32'(m_to));
    if (m_owner >= 0) check("model_gnt_id", 32'(gnt_id), 32'(m_owner));
    check("onehot0_gnt", 32'($onehot0(gnt)), 32'd1);
  end

  // Apply inputs at the falling edge, then wait until just after the rising
  // edge that consumes them.
  task automatic tick(input logic r, input logic [3:0] q);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    req = 4'b0000;
    tick(1'b1, 4'b0000);
    tick(1'b1, 4'b0000);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_gnt",   32'(gnt),   32'd0);
    check("reset_to",    32'(timeout), 32'd0);

    // No requests: stay idle.
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 4'b0000);
      check("idle_gnt", 32'(gnt), 32'd0);
      check("idle_to",  32'(timeout), 32'd0);
    end

    // 0110 from ptr 0 grants 1; release hands to 2 with no bubble.
    tick(1'b0, 4'b0110);
    check("first_gnt", 32'(gnt), 32'b0010);
    check("first_id",  32'(gnt_id), 32'd1);
    tick(1'b0, 4'b0100);
    check("handoff_gnt", 32'(gnt), 32'b0100);
    tick(1'b0, 4'b0000);
    check("drop_all_gnt", 32'(gnt), 32'd0);

    // Full rotation 0,1,2,3,0 with each owner releasing after two cycles.
    tick(1'b1, 4'b0000);
    tick(1'b0, 4'b1111);
    check("rot_id0", 32'(gnt_id), 32'd0);
    tick(1'b0, 4'b1111);
    tick(1'b0, 4'b1110);
    check("rot_id1", 32'(gnt_id), 32'd1);
    tick(1'b0, 4'b1111);
    tick(1'b0, 4'b1101);
    check("rot_id2", 32'(gnt_id), 32'd2);
    tick(1'b0, 4'b1111);
    tick(1'b0, 4'b1011);
    check("rot_id3", 32'(gnt_id), 32'd3);
    tick(1'b0, 4'b1111);
    tick(1'b0, 4'b0111);
    check("rot_wrap_id0", 32'(gnt_id), 32'd0);
    check("rot_wrap_valid", 32'(valid), 32'd1);
    tick(1'b0, 4'b0000);

    // Lone requester keeps the grant; a late competitor triggers an
    // immediate timeout.
    tick(1'b1, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 4'b0001);
      check("lone_gnt", 32'(gnt), 32'b0001);
      check("lone_to",  32'(timeout), 32'd0);
    end
    tick(1'b0, 4'b0101);
    check("late_comp_gnt", 32'(gnt), 32'b0100);
    check("late_comp_to",  32'(timeout), 32'd1);
    tick(1'b0, 4'b0101);
    check("late_comp_to_pulse", 32'(timeout), 32'd0);
    check("late_comp_gnt_hold", 32'(gnt), 32'b0100);
    tick(1'b0, 4'b0000);

    // Two steady requesters alternate every MAX_HOLD cycles.
    tick(1'b1, 4'b0000);
    for (int i = 1; i <= 14; i++) begin
      tick(1'b0, 4'b0011);
      if (i == 4) check("alt_before_switch", 32'(gnt), 32'b0001);
      if (i == 5) begin
        check("alt_switch1_gnt", 32'(gnt), 32'b0010);
        check("alt_switch1_to",  32'(timeout), 32'd1);
      end
      if (i == 9) begin
        check("alt_switch2_gnt", 32'(gnt), 32'b0001);
        check("alt_switch2_to",  32'(timeout), 32'd1);
      end
    end
    tick(1'b0, 4'b0000);

    // Reset mid-grant drops the grant silently; pointer restarts at 0.
    tick(1'b1, 4'b0000);
    tick(1'b0, 4'b1000);
    check("pre_rst_gnt", 32'(gnt), 32'b1000);
    tick(1'b1, 4'b1111);
    check("mid_rst_gnt",   32'(gnt), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_to",    32'(timeout), 32'd0);
    tick(1'b0, 4'b1111);
    check("post_rst_gnt", 32'(gnt), 32'b0001);

    tick(1'b0, 4'b0000);
    tick(1'b0, 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
